imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The core only reads instruction memory; this block fills it.
- Accepts a byte stream from a host over a valid/ready handshake and packs it little-endian into DATA_WIDTH words.
- Writes each word into instruction RAM at consecutive addresses starting at 0.
- Holds the core in reset (cpu_rst) until the image is complete.

Parameters:
- ADDRESS_WIDTH, 5, instruction RAM word-address width; legal range 1..8 because the header is one byte.
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes per word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a (re)load; honoured only in IDLE, DONE or ERROR
- byte_in  in  8  stream byte
- byte_valid  in  1  host has a byte on byte_in
- byte_ready  out  1  loader accepts byte_in this cycle
- wr_en  out  1  instruction RAM write strobe
- wr_addr  out  ADDRESS_WIDTH  instruction RAM word address
- wr_data  out  DATA_WIDTH  instruction RAM write data
- cpu_rst  out  1  active-high reset to the core
- done  out  1  image fully written
- err  out  1  checksum failure (CHECKSUM_EN only, else 0)

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE; all counters and the shift register cleared.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0, cpu_rst=1.
- Transfer rule: a byte is consumed only on a cycle where byte_valid && byte_ready at the rising edge of clk.
- IDLE:
  - byte_ready=0, cpu_rst=1.
  - start → HDR.
- HDR:
  - byte_ready=1.
  - On transfer: last_addr = byte_in[ADDRESS_WIDTH-1:0] (header = word count minus 1; upper bits ignored); byte_idx=0; wr_addr=0 → DATA.
- DATA:
  - byte_ready=1.
  - On transfer: byte lane byte_idx of the word buffer = byte_in (lane 0 = bits 7:0); byte_idx++.
  - On the transfer with byte_idx==3 → WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, wr_en=1; wr_data = the assembled word; wr_addr = current address.
  - wr_en rises the cycle after the 4th byte handshake.
  - If wr_addr==last_addr → DONE (or CHK when CHECKSUM_EN); else wr_addr++, byte_idx=0 → DATA.
- DONE:
  - cpu_rst=0, done=1, byte_ready=0.
  - start → HDR; cpu_rst=1 and done=0 from the next cycle.
- start is ignored in HDR, DATA and WRITE. byte_valid is ignored whenever byte_ready=0.
- wr_en is 0 in every state except WRITE; wr_addr and wr_data hold their last values between writes.
- Boundary cases:
  - Header 0 → exactly one word written.
  - Header 2^ADDRESS_WIDTH-1 → fills the RAM; wr_addr never wraps.
  - Host stalls (byte_valid=0) mid-word → the partial word is held indefinitely.
- Reset mid-load: immediate return to IDLE with cpu_rst=1. RAM contents are undefined, and a new start is required.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last WRITE, go to state CHK with byte_ready=1.
  - The next transferred byte is compared against the XOR of all data bytes received in this load (the header is excluded).
  - Match → DONE.
  - Mismatch → ERROR: err=1, cpu_rst=1, done=0, byte_ready=0. start clears err and goes to HDR.
  - The XOR accumulator is cleared on HDR entry.
- Without the macro: no CHK or ERROR state, no accumulator; err is tied to 0.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, HDR, DATA, WRITE, DONE, CHK, ERROR
  - BYTES_PER_WORD=4
  - byte index width
- One sub-module, byte_packer: shift/lane register, byte_idx counter, word_full flag and clear input.
- The FSM and address counter stay in imem_loader.

Test Plan:
- Reset then start; header 0x00; bytes 13 05 A0 00 → one WRITE: wr_addr=0, wr_data=0x00A00513. Then done=1, cpu_rst=0.
- Header 0x02; 12 bytes sent with byte_valid toggling every other cycle → exactly 3 wr_en pulses at addresses 0,1,2, each 1 cycle after its 4th byte; no write during stalls.
- Header 0x1F; 128 bytes → 32 writes at addresses 0..31; no wrap; done=1 after address 31.
- Assert rst low after 2 data bytes → outputs return to reset values asynchronously. A new start and header 0x00 produces a correct single word with no stale bytes.
- start pulsed during DATA, and byte_valid held high in DONE → both ignored; no extra writes, byte_ready stays 0 in DONE.
- With IMEM_LOADER_CHECKSUM_EN, header 0x00, data 01 02 04 08:
  - checksum 0x0F → done=1.
  - checksum 0x0E → err=1, cpu_rst=1; start then clears err.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      WRITE,
      DONE,
      CHK,
      ERROR
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-RAM write port; master = loader side.
interface imem_loader_if #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32
);
   logic [7:0]               byte_in;
   logic                     byte_valid;
   logic                     byte_ready;
   logic                     wr_en;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_data;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-lane packer: byte 0 lands in bits 7:0.
module imem_loader_byte_packer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word_nxt,
   output logic                  word_full
);
   import imem_loader_pkg::*;

   logic [DATA_WIDTH-1:0] word_q, word_d;
   byte_idx_t             idx_q, idx_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clear) begin
         word_d = '0;
         idx_d  = '0;
      end else if (load) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_in;
         idx_d                        = idx_q + byte_idx_t'(1);
      end
   end

   // word_nxt exposes the word including the byte being accepted this cycle
   assign word_nxt  = word_d;
   assign word_full = load && !clear && (idx_q == byte_idx_t'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header byte, then packed words written from address 0.
// Optional trailing XOR checksum byte with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_rst,
   output logic          done,
   output logic          err
);
   import imem_loader_pkg::*;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0] last_q, last_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                     xfer;
   logic                     pk_clear, pk_load, word_full;
   logic [DATA_WIDTH-1:0]    word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]               csum_q, csum_d;
`endif

   assign xfer     = bus.byte_valid && bus.byte_ready;
   assign pk_load  = (state_q == DATA) && xfer;
   assign pk_clear = ((state_q == HDR) && xfer) || (state_q == WRITE);

   imem_loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clear    (pk_clear),
      .load     (pk_load),
      .byte_in  (bus.byte_in),
      .word_nxt (word_nxt),
      .word_full(word_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = HDR;
         HDR:               if (xfer) state_d = DATA;
         DATA:              if (word_full) state_d = WRITE;
         WRITE: begin
            if (addr_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CHK;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: if (xfer) state_d = (bus.byte_in == csum_q) ? DONE : ERROR;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
      bus.wr_en      = (state_q == WRITE);
      cpu_rst        = (state_q != DONE);
      done           = (state_q == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      err            = (state_q == ERROR);
`else
      err            = 1'b0;
`endif
   end

   always_comb begin
      addr_d    = addr_q;
      last_d    = last_q;
      wr_data_d = wr_data_q;
      if ((state_q == HDR) && xfer) begin
         last_d = bus.byte_in[ADDRESS_WIDTH-1:0];
         addr_d = '0;
      end
      if (word_full) begin
         wr_data_d = word_nxt;
      end
      // address only advances when another word follows, so it never wraps
      if ((state_q == WRITE) && (addr_q != last_q)) begin
         addr_d = addr_q + ADDRESS_WIDTH'(1);
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_comb begin
      csum_d = csum_q;
      if ((state_d == HDR) && (state_q != HDR)) begin
         csum_d = '0;
      end else if (pk_load) begin
         csum_d = csum_q ^ bus.byte_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q    <= '0;
         last_q    <= '0;
         wr_data_q <= '0;
      end else begin
         addr_q    <= addr_d;
         last_q    <= last_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.wr_addr = addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader against a byte-list reference model.
module tb_imem_loader;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam logic [7:0]  HDR_MASK = 8'((1 << AW) - 1);

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic cpu_rst, done, err;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   typedef struct {
      int unsigned         c;
      logic [AW-1:0]       a;
      logic [DW-1:0]       d;
   } wr_t;

   wr_t        wq[$];
   logic [7:0] img[$];

   imem_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus.master),
      .cpu_rst(cpu_rst),
      .done   (done),
      .err    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) wq.push_back('{cyc, bus.wr_addr, bus.wr_data});
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap, output int unsigned c);
      bit ok;
      repeat (gap) begin @(posedge clk); #1; end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      ok = 1'b0;
      c  = 0;
      for (int unsigned t = 0; t < 20; t++) begin
         if (bus.byte_ready === 1'b1) begin
            c  = cyc;
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      chk("handshake", 64'(ok), 64'd1);
   endtask

   task automatic fill_random(input int unsigned nwords);
      img.delete();
      repeat (4 * nwords) img.push_back(8'($urandom));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdy"},     64'(bus.byte_ready), 64'd0);
      chk({tag, "_wr_en"},   64'(bus.wr_en),      64'd0);
      chk({tag, "_wr_addr"}, 64'(bus.wr_addr),    64'd0);
      chk({tag, "_wr_data"}, 64'(bus.wr_data),    64'd0);
      chk({tag, "_done"},    64'(done),           64'd0);
      chk({tag, "_err"},     64'(err),            64'd0);
      chk({tag, "_cpu_rst"}, 64'(cpu_rst),        64'd1);
   endtask

   // Streams header + img (+ checksum byte) and compares the write log with the model.
   task automatic run_load(input logic [7:0] hdr, input int unsigned gap,
                           input bit mid_start, input bit bad_csum);
      int unsigned acc_c;
      int unsigned n;
      int unsigned exp_c[$];
      logic [7:0]  x;
      logic [DW-1:0] w;
      bit          exp_err;
      n       = int'(hdr & HDR_MASK) + 1;
      x       = 8'h00;
      exp_err = 1'b0;
      wq.delete();
      pulse_start();
      send_byte(hdr, gap, acc_c);
      for (int i = 0; i < img.size(); i++) begin
         send_byte(img[i], gap, acc_c);
         x = x ^ img[i];
         if (i % 4 == 3) exp_c.push_back(acc_c + 1);
         if (mid_start && i == 1) pulse_start();
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (x ^ 8'h01) : x, gap, acc_c);
      exp_err = bad_csum;
`endif
      for (int k = 0; k < 40 && done !== 1'b1 && err !== 1'b1; k++) begin
         @(posedge clk); #1;
      end
      chk("end_done",    64'(done),           64'(!exp_err));
      chk("end_err",     64'(err),            64'(exp_err));
      chk("end_cpu_rst", 64'(cpu_rst),        64'(exp_err));
      chk("end_rdy",     64'(bus.byte_ready), 64'd0);
      chk("num_writes",  64'(wq.size()),      64'(n));
      for (int k = 0; k < n && k < wq.size(); k++) begin
         w = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
         chk("wr_addr", 64'(wq[k].a), 64'(k));
         chk("wr_data", 64'(wq[k].d), 64'(w));
         chk("wr_cycle", 64'(wq[k].c), 64'(exp_c[k]));
      end
      w = {img[4*n-1], img[4*n-2], img[4*n-3], img[4*n-4]};
      chk("addr_hold", 64'(bus.wr_addr), 64'(n - 1));
      chk("data_hold", 64'(bus.wr_data), 64'(w));
      bus.byte_valid = 1'b1;
      repeat (4) begin
         bus.byte_in = 8'($urandom);
         @(posedge clk); #1;
         chk("rdy_after", 64'(bus.byte_ready), 64'd0);
      end
      bus.byte_valid = 1'b0;
      chk("no_extra_wr", 64'(wq.size()), 64'(n));
   endtask

   initial begin
      int unsigned c;
      int unsigned h;
      rst            = 1'b0;
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      #1;
      check_reset_outputs("por");
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;

      // Valid without start must be ignored in IDLE.
      bus.byte_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_rdy", 64'(bus.byte_ready), 64'd0);
      bus.byte_valid = 1'b0;

      img = '{8'h13, 8'h05, 8'hA0, 8'h00};
      run_load(8'h00, 0, 1'b0, 1'b0);
      chk("first_word", 64'(bus.wr_data), 64'h0000_0000_00A0_0513);

      fill_random(3);
      run_load(8'h02, 1, 1'b0, 1'b0);

      fill_random(32);
      run_load(8'h1F, 0, 1'b0, 1'b0);

      fill_random(2);
      run_load(8'hE1, $urandom_range(0, 2), 1'b0, 1'b0);

      // Asynchronous reset after two data bytes.
      pulse_start();
      send_byte(8'h00, 0, c);
      send_byte(8'hAA, 0, c);
      send_byte(8'h55, 0, c);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b1;
      fill_random(1);
      run_load(8'h00, 0, 1'b0, 1'b0);

      fill_random(2);
      run_load(8'h01, 0, 1'b1, 1'b0);

      repeat (4) begin
         h = $urandom_range(0, 5);
         fill_random(h + 1);
         run_load(8'(h), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      img = '{8'h01, 8'h02, 8'h04, 8'h08};
      run_load(8'h00, 0, 1'b0, 1'b0);
      img = '{8'h01, 8'h02, 8'h04, 8'h08};
      run_load(8'h00, 0, 1'b0, 1'b1);
      pulse_start();
      chk("err_cleared", 64'(err),            64'd0);
      chk("err_to_hdr",  64'(bus.byte_ready), 64'd1);
      fill_random(1);
      run_load(8'h00, 0, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
